// File: rtl/uart_frame_streamer.sv
// Frame sender: streams one image from the SDRAM read FIFO to the UART transmitter.
// The image is framed by a 7-byte header and a checksum/end-marker trailer.
module uart_frame_streamer #(
  parameter int unsigned WIDTH      = 640,
  parameter int unsigned HEIGHT     = 480,
  parameter int unsigned CHANNELS   = 3,
  parameter int unsigned CH_BITS    = 10,
  parameter int unsigned RD_LATENCY = 2,
  parameter logic [7:0]  END_BYTE   = 8'h55
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         en_i,
  output logic                         pix_rd_req_o,
  input  logic [CHANNELS*CH_BITS-1:0]  pix_data_i,
  output logic [7:0]                   tx_data_o,
  output logic                         tx_start_o,
  input  logic                         tx_busy_i,
  input  logic                         tx_done_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         aborted_o,
  output logic [31:0]                  pixel_count_o,
  output logic [3:0]                   state_o
);

  localparam logic [3:0] StIdle   = 4'd0;
  localparam logic [3:0] StHdr    = 4'd1;
  localparam logic [3:0] StRd     = 4'd2;
  localparam logic [3:0] StRdWait = 4'd3;
  localparam logic [3:0] StCh     = 4'd4;
  localparam logic [3:0] StTrl    = 4'd5;
  localparam logic [3:0] StWaitTx = 4'd6;
  localparam logic [3:0] StDone   = 4'd7;

  localparam logic [31:0] NumPixels = WIDTH * HEIGHT;
  localparam logic [15:0] Width16   = 16'(WIDTH);
  localparam logic [15:0] Height16  = 16'(HEIGHT);
  localparam logic [7:0]  Chan8     = 8'(CHANNELS);
  localparam logic [2:0]  LatLast   = 3'(RD_LATENCY);
  localparam logic [2:0]  ChLast    = 3'(CHANNELS - 1);

  logic [3:0]                  state_q, state_d;
  logic [3:0]                  ret_q, ret_d;      // state to resume after WAIT_TX
  logic [2:0]                  idx_q, idx_d;      // header, channel or trailer byte index
  logic [2:0]                  lat_q, lat_d;
  logic [CHANNELS*CH_BITS-1:0] pix_q, pix_d;
  logic [7:0]                  csum_q, csum_d;
  logic [31:0]                 pcnt_q, pcnt_d;
  logic [7:0]                  tx_data_q, tx_data_d;
  logic                        tx_start_q, tx_start_d;
  logic                        rd_req_q, rd_req_d;
  logic                        aborted_q, aborted_d;

  logic [7:0] ch_byte [CHANNELS];
  logic [7:0] cur_ch;
  logic [7:0] hdr_byte;

  // MSB-align each channel into 16 bits; the top byte is then correct for any CH_BITS.
  for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
    logic [15:0] aligned;
    assign aligned    = 16'(pix_q[k*CH_BITS +: CH_BITS]) << (16 - CH_BITS);
    assign ch_byte[k] = aligned[15:8];
  end

  // Select the channel byte addressed by the current index.
  always_comb begin
    cur_ch = 8'h00;
    for (int k = 0; k < CHANNELS; k++) begin
      if (idx_q == 3'(k)) cur_ch = ch_byte[k];
    end
  end

  // Header byte lookup.
  always_comb begin
    case (idx_q)
      3'd0:    hdr_byte = 8'hA5;
      3'd1:    hdr_byte = 8'h5A;
      3'd2:    hdr_byte = Width16[15:8];
      3'd3:    hdr_byte = Width16[7:0];
      3'd4:    hdr_byte = Height16[15:8];
      3'd5:    hdr_byte = Height16[7:0];
      default: hdr_byte = Chan8;
    endcase
  end

  // Next-state logic for the frame sequencer.
  always_comb begin
    state_d    = state_q;
    ret_d      = ret_q;
    idx_d      = idx_q;
    lat_d      = lat_q;
    pix_d      = pix_q;
    csum_d     = csum_q;
    pcnt_d     = pcnt_q;
    tx_data_d  = tx_data_q;
    tx_start_d = 1'b0;
    rd_req_d   = 1'b0;
    aborted_d  = 1'b0;

    case (state_q)
      StIdle: begin
        if (en_i) begin
          state_d = StHdr;
          csum_d  = 8'h00;
          pcnt_d  = 32'd0;
          idx_d   = 3'd0;
        end
      end
      StHdr: begin
        if (!en_i) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (!tx_busy_i) begin
          tx_data_d  = hdr_byte;
          tx_start_d = 1'b1;
          ret_d      = StHdr;
          state_d    = StWaitTx;
        end
      end
      StRd: begin
        if (!en_i) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (pcnt_q == NumPixels) begin
          idx_d   = 3'd0;
          state_d = StTrl;
        end else begin
          rd_req_d = 1'b1;
          lat_d    = 3'd0;
          state_d  = StRdWait;
        end
      end
      StRdWait: begin
        // lat_q is 0 while the read pulse is visible, so data is captured RD_LATENCY later.
        if (!en_i) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (lat_q == LatLast) begin
          pix_d   = pix_data_i;
          idx_d   = 3'd0;
          state_d = StCh;
        end else begin
          lat_d = lat_q + 3'd1;
        end
      end
      StCh: begin
        if (!en_i) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (!tx_busy_i) begin
          tx_data_d  = cur_ch;
          tx_start_d = 1'b1;
          csum_d     = csum_q + cur_ch;
          ret_d      = StCh;
          state_d    = StWaitTx;
        end
      end
      StTrl: begin
        if (!en_i) begin
          state_d   = StIdle;
          aborted_d = 1'b1;
        end else if (!tx_busy_i) begin
          tx_data_d  = (idx_q == 3'd0) ? csum_q : END_BYTE;
          tx_start_d = 1'b1;
          ret_d      = StTrl;
          state_d    = StWaitTx;
        end
      end
      StWaitTx: begin
        // tx_busy is ignored here, so a simultaneous tx_done always completes the byte.
        if (tx_done_i) begin
          if (!en_i) begin
            state_d   = StIdle;
            aborted_d = 1'b1;
          end else begin
            case (ret_q)
              StHdr: begin
                if (idx_q == 3'd6) begin
                  idx_d   = 3'd0;
                  state_d = StRd;
                end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = StHdr;
                end
              end
              StCh: begin
                if (idx_q == ChLast) begin
                  idx_d   = 3'd0;
                  pcnt_d  = pcnt_q + 32'd1;
                  state_d = StRd;
                end else begin
                  idx_d   = idx_q + 3'd1;
                  state_d = StCh;
                end
              end
              default: begin
                if (idx_q == 3'd0) begin
                  idx_d   = 3'd1;
                  state_d = StTrl;
                end else begin
                  state_d = StDone;
                end
              end
            endcase
          end
        end
      end
      StDone: begin
        if (!en_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      ret_q      <= StIdle;
      idx_q      <= 3'd0;
      lat_q      <= 3'd0;
      pix_q      <= '0;
      csum_q     <= 8'h00;
      pcnt_q     <= 32'd0;
      tx_data_q  <= 8'h00;
      tx_start_q <= 1'b0;
      rd_req_q   <= 1'b0;
      aborted_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      ret_q      <= ret_d;
      idx_q      <= idx_d;
      lat_q      <= lat_d;
      pix_q      <= pix_d;
      csum_q     <= csum_d;
      pcnt_q     <= pcnt_d;
      tx_data_q  <= tx_data_d;
      tx_start_q <= tx_start_d;
      rd_req_q   <= rd_req_d;
      aborted_q  <= aborted_d;
    end
  end

  assign pix_rd_req_o  = rd_req_q;
  assign tx_data_o     = tx_data_q;
  assign tx_start_o    = tx_start_q;
  assign busy_o        = (state_q != StIdle) && (state_q != StDone);
  assign done_o        = (state_q == StDone);
  assign aborted_o     = aborted_q;
  assign pixel_count_o = pcnt_q;
  assign state_o       = state_q;

endmodule

// File: doc/uart_frame_streamer.md
Name: uart_frame_streamer

Overview:
- Parametrised next-generation frame sender: reads WIDTH*HEIGHT pixel words from the SDRAM read-side FIFO, splits each word into CHANNELS colour channels, and streams them one byte per channel over the UART transmitter handshake.
- Wraps the payload in a fixed header (sync, dimensions, channel count) and a trailer (8-bit checksum plus end marker) so the host can frame and validate each image.
- Sits between the SDRAM read FIFO and the UART TX core in the door-camera capture path.

Parameters:
- WIDTH, 640: pixels per line (1..65535).
- HEIGHT, 480: lines per frame (1..65535).
- CHANNELS, 3: channels per pixel word (1..4).
- CH_BITS, 10: bits per channel (1..16).
- RD_LATENCY, 2: cycles from a pix_rd_req pulse to valid pix_data (1..4).
- END_BYTE, 8'h55: final trailer byte.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  level request; rising-level start, must stay high for the whole frame.
- pix_rd_req  out  1  one-cycle read pulse to the FIFO.
- pix_data  in  CHANNELS*CH_BITS  pixel word; channel k occupies bits [k*CH_BITS +: CH_BITS].
- tx_data  out  8  byte to the UART.
- tx_start  out  1  one-cycle send strobe.
- tx_busy  in  1  UART busy.
- tx_done  in  1  one-cycle pulse when a byte completes.
- busy  out  1  high from leaving IDLE until DONE or abort.
- done  out  1  high in DONE.
- aborted  out  1  one-cycle pulse when a frame is abandoned.
- pixel_count  out  32  pixels fully sent in the current frame.
- state  out  4  debug state code.

Behaviour:
- Reset (synchronous, wins over everything, including mid-frame): state=IDLE. All outputs are 0: tx_data, tx_start, pix_rd_req, busy, done, aborted, pixel_count. Internal counters and checksum are also cleared.
- States and codes:
  - IDLE 0
  - HDR 1
  - RD 2
  - RD_WAIT 3
  - CH 4
  - TRL 5
  - WAIT_TX 6
  - DONE 7
- IDLE: when en=1, go to HDR; clear checksum, pixel_count and the byte index.
- Byte send rule (HDR, CH, TRL):
  - When tx_busy=0, drive tx_data and pulse tx_start for exactly 1 cycle, then enter WAIT_TX.
  - WAIT_TX returns to the calling state on tx_done and advances the byte or channel index.
  - Never more than one outstanding byte.
  - If tx_done and tx_busy are high together, tx_done wins.
- HDR sends 7 bytes in order: 8'hA5, 8'h5A, WIDTH[15:8], WIDTH[7:0], HEIGHT[15:8], HEIGHT[7:0], CHANNELS. It then goes to RD.
- RD:
  - If pixel_count==WIDTH*HEIGHT, go to TRL.
  - Otherwise pulse pix_rd_req for 1 cycle and go to RD_WAIT.
- RD_WAIT: count RD_LATENCY cycles, register pix_data on the last one, then go to CH with channel=0.
- CH channel byte:
  - If CH_BITS>=8, the byte is the channel's top 8 bits.
  - If CH_BITS<8, the byte is the channel left-shifted to be MSB-aligned, with zero fill.
  - Channels are sent in order 0..CHANNELS-1.
  - Each sent byte is added to the checksum (mod 256).
  - After the last channel, pixel_count increments and the block returns to RD.
- TRL sends the checksum, then END_BYTE, then goes to DONE.
- DONE: done=1; stays until en=0, then returns to IDLE.
- Abort:
  - Triggered by en=0 in any state other than IDLE, DONE or WAIT_TX. If en falls during WAIT_TX, the abort is taken after tx_done.
  - On abort, pulse aborted, go to IDLE, and send no trailer.
- pixel_count uses 32-bit arithmetic, so a full frame cannot wrap.
- Total bytes per frame = 9 + WIDTH*HEIGHT*CHANNELS.

Test Plan:
- Common bench setup for all scenarios: WIDTH=4, HEIGHT=2, CHANNELS=3, CH_BITS=10. The UART model raises tx_busy for 10 cycles after tx_start, then pulses tx_done.
- Full frame: pix_data={10'h00C,10'h008,10'h004} constant, en=1 → 33 bytes in this order:
  - A5 5A 00 04 00 02 03
  - then 8×(01 02 03)
  - then checksum 30, then 55.
  - Final state: done=1, pixel_count=8, exactly 8 pix_rd_req pulses.
- Latency: RD_LATENCY=3; pix_data is valid only on the 3rd cycle after pix_rd_req, garbage otherwise → bytes still 01 02 03 per pixel.
- Back-pressure: hold tx_busy=1 for 50 cycles before the first header byte → tx_start is not asserted until tx_busy=0, then tx_data=A5.
- Abort: drop en after pixel 3 completes → aborted pulses once, no 30/55 trailer is sent, state=IDLE. Re-raising en restarts with A5 and pixel_count=0.
- Reset mid-frame: assert rst during WAIT_TX → next cycle all outputs are 0 and state=IDLE. A following frame is byte-exact against the full-frame scenario.
- CH_BITS=6 with a channel value of 6'h3F → byte FC.
